mem_stage: RTL
==============

Name: mem_stage

Overview:
- Memory-access pipeline stage between the execute stage and writeback.
- Consumes the EX/MEM register: ALU result/address, store data, rd, funct3, control bits.
- Drives a req/gnt/rvalid data-memory port, formats loads and stores, and flags misaligned accesses.
- Stalls the pipeline while an access is in flight and registers the final result into the MEM/WB register.

Parameters:
XLEN, 32, datapath and address width (only 32 supported)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
stall_in  in  1  global hazard stall; holds MEM/WB register and blocks new requests
flush  in  1  kill instruction currently in MEM
alu_result_in  in  XLEN  address (loads/stores) or result (others, incl. PC+4 for jumps)
rs2_data_in  in  XLEN  store data
rd_in  in  5  destination register
funct3_in  in  3  access size/sign
valid_in  in  1  instruction valid
mem_read_in  in  1  load
mem_write_in  in  1  store
reg_write_in  in  1  register write enable
wb_sel_in  in  2  00 ALU, 01 memory, 10 PC+4
dmem_req  out  1  request valid
dmem_we  out  1  1 = store
dmem_addr  out  XLEN  word address, bits[1:0] = 0
dmem_be  out  4  byte enables
dmem_wdata  out  XLEN  lane-aligned store data
dmem_gnt  in  1  request accepted
dmem_rvalid  in  1  load data valid
dmem_rdata  in  XLEN  load word
mem_stall  out  1  stall upstream stages
wb_data_out  out  XLEN  writeback value
rd_out  out  5  MEM/WB rd
reg_write_out  out  1  MEM/WB write enable
valid_out  out  1  MEM/WB valid
misaligned_out  out  1  MEM/WB misaligned-access exception
fault_addr_out  out  XLEN  faulting address when misaligned_out = 1
fwd_data  out  XLEN  equals wb_data_out, for EX forwarding

Behaviour:
- Reset: FSM = IDLE; all outputs 0; load buffer cleared; bus responses during reset are ignored.
- Access condition: acc = valid_in & (mem_read_in | mem_write_in).
- Misalignment:
  - Halfword (funct3[1:0] = 01) with addr[0] = 1.
  - Word (funct3[1:0] = 1x) with addr[1:0] ≠ 00.
  - Misaligned access issues no bus request and completes in 1 cycle.
  - Result: valid_out = 1, misaligned_out = 1, fault_addr_out = address, reg_write_out = 0.
- Store formatting:
  - SB: be = 0001 << off, wdata = byte replicated ×4.
  - SH: be = 0011 << off, wdata = halfword replicated ×2.
  - SW: be = 1111.
  - off = addr[1:0]; dmem_addr = {addr[31:2], 00}.
- Load formatting (off = addr[1:0]):
  - LB/LBU: select byte at off; sign-extend (000) or zero-extend (100).
  - LH/LHU: select halfword at off[1]; sign-extend (001) or zero-extend (101).
  - Any funct3[1:0] = 11 is treated as a word access.
- FSM states:
  - IDLE:
    - dmem_req = acc & ~misaligned & ~stall_in & ~flush (combinational).
    - Store + gnt: complete this cycle, stay in IDLE.
    - Load + gnt: go to WAIT.
    - Req without gnt: go to REQ.
  - REQ:
    - Hold req with identical addr/be/wdata/we until gnt.
    - flush with no gnt: drop req, return to IDLE (retraction is legal before gnt).
    - On gnt: same exits as IDLE.
  - WAIT:
    - rvalid arrives at the earliest 1 cycle after gnt.
    - On rvalid: capture formatted data into load buffer.
    - rvalid & ~stall_in: complete, go to IDLE.
    - rvalid & stall_in: go to DONE.
    - flush: go to DRAIN.
  - DONE: hold buffered data; complete when ~stall_in, then IDLE; flush returns to IDLE with the result discarded.
  - DRAIN: await rvalid, discard data, go to IDLE. mem_stall stays 1 throughout.
- mem_stall = acc & ~misaligned & ~(this cycle completes), plus any non-IDLE state.
- MEM/WB register:
  - Loads when ~stall_in and the instruction completes (non-memory instructions complete immediately).
  - flush or mem_stall loads a bubble (valid_out = 0, reg_write_out = 0).
  - wb_data_out = formatted load data if wb_sel = 01, else alu_result_in.
- Simultaneous events:
  - flush takes priority over completion.
  - stall_in with an in-flight load uses DONE; no response is ever lost.

Test Plan:
- Reset: rst = 1 for 2 cycles mid-WAIT -> all outputs 0, FSM IDLE, later rvalid ignored.
- Store byte: SB to 0x1003, rs2 = 0x000000AB, gnt same cycle -> dmem_addr = 0x1000, be = 1000, wdata = 0xABABABAB, mem_stall = 0, reg_write_out = 0 next cycle.
- Load sign-extend: LH at 0x2002, gnt after 2 cycles, rvalid 3 cycles later with rdata = 0x8001_1234 -> wb_data_out = 0xFFFF8001; mem_stall high for exactly 5 cycles; repeat as LHU -> 0x00008001.
- Misaligned: LW at 0x3001 -> no dmem_req; next cycle valid_out = 1, misaligned_out = 1, fault_addr_out = 0x3001, reg_write_out = 0.
- Stall on return: LW at 0x40 with stall_in high as rvalid arrives (rdata = 0xDEADBEEF), stall_in held 3 more cycles -> data held in DONE; wb_data_out = 0xDEADBEEF on the cycle after stall_in drops.
- Flush in WAIT: flush one cycle after gnt -> mem_stall stays 1 until rvalid; then valid_out = 0, reg_write_out = 0; the next ADD (alu_result = 7) writes back 7.

Source files
------------

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: issues data-memory requests over a req/gnt/rvalid
// port, formats loads/stores, detects misalignment and registers the MEM/WB result.
module mem_stage #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall_in,
    input  logic            flush,
    input  logic [XLEN-1:0] alu_result_in,
    input  logic [XLEN-1:0] rs2_data_in,
    input  logic [4:0]      rd_in,
    input  logic [2:0]      funct3_in,
    input  logic            valid_in,
    input  logic            mem_read_in,
    input  logic            mem_write_in,
    input  logic            reg_write_in,
    input  logic [1:0]      wb_sel_in,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic [XLEN-1:0] dmem_addr,
    output logic [3:0]      dmem_be,
    output logic [XLEN-1:0] dmem_wdata,
    input  logic            dmem_gnt,
    input  logic            dmem_rvalid,
    input  logic [XLEN-1:0] dmem_rdata,
    output logic            mem_stall,
    output logic [XLEN-1:0] wb_data_out,
    output logic [4:0]      rd_out,
    output logic            reg_write_out,
    output logic            valid_out,
    output logic            misaligned_out,
    output logic [XLEN-1:0] fault_addr_out,
    output logic [XLEN-1:0] fwd_data
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_WAIT  = 3'd2,
        S_DONE  = 3'd3,
        S_DRAIN = 3'd4
    } state_t;

    state_t          state;
    state_t          state_nxt;

    logic            acc;
    logic            is_store;
    logic [1:0]      off;
    logic            misaligned_c;
    logic            issue_c;
    logic            complete_c;
    logic            stall_c;
    logic [3:0]      be_fmt;
    logic [XLEN-1:0] wdata_fmt;
    logic [XLEN-1:0] load_data_c;
    logic [XLEN-1:0] lbuf;

    // Copy of the issued request, held stable while waiting for gnt/rvalid
    logic [XLEN-1:0] q_addr;
    logic [3:0]      q_be;
    logic [XLEN-1:0] q_wdata;
    logic            q_we;
    logic [2:0]      q_f3;
    logic [1:0]      q_off;

    function automatic logic [XLEN-1:0] fmt_load(input logic [XLEN-1:0] word,
                                                 input logic [2:0]      f3,
                                                 input logic [1:0]      boff);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{boff, 3'b000} +: 8];
        h = boff[1] ? word[31:16] : word[15:0];
        case (f3[1:0])
            2'b00:   fmt_load = f3[2] ? {{(XLEN-8){1'b0}}, b} : {{(XLEN-8){b[7]}}, b};
            2'b01:   fmt_load = f3[2] ? {{(XLEN-16){1'b0}}, h} : {{(XLEN-16){h[15]}}, h};
            default: fmt_load = word;
        endcase
    endfunction

    assign acc          = valid_in & (mem_read_in | mem_write_in);
    assign is_store     = mem_write_in;
    assign off          = alu_result_in[1:0];
    assign misaligned_c = acc & (((funct3_in[1:0] == 2'b01) & off[0]) |
                                 (funct3_in[1] & (off != 2'b00)));
    assign issue_c      = (state == S_IDLE) & acc & ~misaligned_c & ~stall_in & ~flush & ~rst;

    // Store lane placement
    always_comb begin
        be_fmt    = 4'b1111;
        wdata_fmt = rs2_data_in;
        case (funct3_in[1:0])
            2'b00: begin
                be_fmt    = 4'b0001 << off;
                wdata_fmt = {4{rs2_data_in[7:0]}};
            end
            2'b01: begin
                be_fmt    = 4'b0011 << off;
                wdata_fmt = {2{rs2_data_in[15:0]}};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic; flush always wins over completion
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (issue_c) begin
                    if (!dmem_gnt)     state_nxt = S_REQ;
                    else if (!is_store) state_nxt = S_WAIT;
                end
            end
            S_REQ: begin
                if (dmem_gnt) begin
                    if (q_we)       state_nxt = (stall_in & ~flush) ? S_DONE : S_IDLE;
                    else            state_nxt = flush ? S_DRAIN : S_WAIT;
                end else if (flush) begin
                    state_nxt = S_IDLE;
                end
            end
            S_WAIT: begin
                if (flush)            state_nxt = dmem_rvalid ? S_IDLE : S_DRAIN;
                else if (dmem_rvalid) state_nxt = stall_in ? S_DONE : S_IDLE;
            end
            S_DONE: begin
                if (flush || !stall_in) state_nxt = S_IDLE;
            end
            S_DRAIN: begin
                if (dmem_rvalid) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Bus drive, completion and stall
    always_comb begin
        dmem_req   = 1'b0;
        dmem_we    = 1'b0;
        dmem_addr  = '0;
        dmem_be    = 4'b0000;
        dmem_wdata = '0;
        complete_c = 1'b0;
        stall_c    = 1'b0;
        if (!rst) begin
            case (state)
                S_IDLE: begin
                    dmem_req = issue_c;
                    if (issue_c) begin
                        dmem_we    = is_store;
                        dmem_addr  = {alu_result_in[XLEN-1:2], 2'b00};
                        dmem_be    = be_fmt;
                        dmem_wdata = is_store ? wdata_fmt : '0;
                    end
                    complete_c = ~acc | misaligned_c | (issue_c & dmem_gnt & is_store);
                    stall_c    = acc & ~misaligned_c & ~complete_c;
                end
                S_REQ: begin
                    dmem_req   = 1'b1;
                    dmem_we    = q_we;
                    dmem_addr  = q_addr;
                    dmem_be    = q_be;
                    dmem_wdata = q_wdata;
                    complete_c = dmem_gnt & q_we & ~stall_in & ~flush;
                    stall_c    = ~complete_c;
                end
                S_WAIT: begin
                    complete_c = dmem_rvalid & ~stall_in & ~flush;
                    stall_c    = ~complete_c;
                end
                S_DONE: begin
                    complete_c = ~stall_in & ~flush;
                    stall_c    = ~complete_c;
                end
                S_DRAIN: stall_c = 1'b1;
                default: ;
            endcase
        end
    end

    assign mem_stall   = stall_c;
    assign load_data_c = (state == S_DONE) ? lbuf : fmt_load(dmem_rdata, q_f3, q_off);

    always_ff @(posedge clk) begin
        if (rst) begin
            q_addr  <= '0;
            q_be    <= 4'b0000;
            q_wdata <= '0;
            q_we    <= 1'b0;
            q_f3    <= 3'b000;
            q_off   <= 2'b00;
        end else if (issue_c) begin
            q_addr  <= {alu_result_in[XLEN-1:2], 2'b00};
            q_be    <= be_fmt;
            q_wdata <= is_store ? wdata_fmt : '0;
            q_we    <= is_store;
            q_f3    <= funct3_in;
            q_off   <= off;
        end
    end

    // Load buffer keeps a response that arrived while the pipe was stalled
    always_ff @(posedge clk) begin
        if (rst)                                    lbuf <= '0;
        else if ((state == S_WAIT) && dmem_rvalid)  lbuf <= fmt_load(dmem_rdata, q_f3, q_off);
    end

    // MEM/WB register
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_data_out    <= '0;
            rd_out         <= 5'd0;
            reg_write_out  <= 1'b0;
            valid_out      <= 1'b0;
            misaligned_out <= 1'b0;
            fault_addr_out <= '0;
        end else if (!stall_in) begin
            if (flush || stall_c || !complete_c || !valid_in) begin
                valid_out      <= 1'b0;
                reg_write_out  <= 1'b0;
                misaligned_out <= 1'b0;
            end else begin
                valid_out      <= 1'b1;
                rd_out         <= rd_in;
                misaligned_out <= misaligned_c;
                reg_write_out  <= reg_write_in & ~misaligned_c;
                fault_addr_out <= misaligned_c ? alu_result_in : '0;
                wb_data_out    <= (!misaligned_c && (wb_sel_in == 2'b01)) ? load_data_c
                                                                          : alu_result_in;
            end
        end
    end

    assign fwd_data = wb_data_out;

endmodule
